fft_ram_sequencer: RTL and testbench
====================================

# fft_ram_sequencer

Circuit-side initiator for the shared 4096×32 sample RAM. On `start` it takes the RAM away from the AXI side (`mode`=0), streams N samples to the FFT core in bit-reversed address order, accepts N 32-bit results back in natural order and writes them into RAM, then returns the RAM to the AXI side (`mode`=1) and pulses `done`. It drives the RAM's circuit-side ports (`mode`, `write_to_cache`, `read_ram_to_cache`, `cir_adr_in`, `cir_data_in`) and consumes `cir_data_out`.

## Interface
- `ADDR_W`, 12: RAM address width.
- `N_LOG2`, 10: log2 of transform length N. Legal range 1..`ADDR_W`.
- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `start` in 1: begin one transform. Sampled only in IDLE.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse on completion.
- `mode` out 1: RAM owner select; 1 = AXI side, 0 = circuit side.
- `write_to_cache` out 1: RAM read strobe on the circuit side.
- `read_ram_to_cache` out `ADDR_W`: RAM read address.
- `cir_data_out` in 16: RAM read data, valid 1 cycle after its address.
- `cir_adr_in` out `ADDR_W`: RAM write address.
- `cir_data_in` out 32: RAM write data.
- `smp_data` out 16: sample to core (= `cir_data_out`).
- `smp_valid` out 1, `smp_ready` in 1: sample handshake.
- `smp_last` out 1: high with sample N-1.
- `res_data` in 32, `res_valid` in 1, `res_ready` out 1: result handshake.

## Operation
- States: IDLE, PRIME, LOAD, STORE, FINISH.
- IDLE: `mode`=1, `write_to_cache`=0, `smp_valid`=0, `res_ready`=0. `start`=1 -> PRIME; idx and wr_idx are cleared to 0.
- RAM rule: with `mode`=0 the RAM writes on every cycle in which `write_to_cache`=0. Every non-IDLE cycle therefore keeps `write_to_cache`=1, except a cycle that actually commits a result.
- Read address is `read_ram_to_cache` = {zeros, bitrev_N_LOG2(idx_next)}. The reversal uses the low `N_LOG2` bits; the upper bits are 0.
  - idx_next = idx + 1 on a sample handshake (`smp_valid`&`smp_ready`), else idx.
  - The address is combinational, so `cir_data_out` always corresponds to bitrev(idx).
- PRIME: one cycle, `smp_valid`=0. The address is bitrev(0). Next state is LOAD.
- LOAD: `smp_valid`=1, `smp_data`=`cir_data_out`, `smp_last`=(idx==N-1).
  - A handshake with idx<N-1 increments idx; full throughput, one sample per cycle.
  - A handshake with idx==N-1 -> STORE.
  - With `smp_ready`=0 the address is re-issued, and the data holds stable.
- STORE: `res_ready`=1, `smp_valid`=0.
  - A cycle with `res_valid`=1 drives `write_to_cache`=0, `cir_adr_in`=wr_idx, `cir_data_in`=`res_data`, and increments wr_idx. On wr_idx==N-1 -> FINISH.
  - A cycle with `res_valid`=0 drives `write_to_cache`=1, a harmless read stall.
  - Results are stored in natural order at addresses 0..N-1.
- FINISH: `mode`=1, `done`=1 for exactly this cycle, `write_to_cache`=0. Next state is IDLE.
- `start` outside IDLE is ignored. `res_valid` outside STORE is not accepted, because `res_ready`=0.
- Reset values: state IDLE; `mode`=1; `busy`, `done`, `write_to_cache`, `smp_valid`, `smp_last`, `res_ready` = 0; `read_ram_to_cache`, `cir_adr_in`, `cir_data_in` = 0; idx and wr_idx = 0.
- Reset mid-operation: the block is in IDLE with `mode`=1 on the next cycle, and no further RAM writes occur. RAM contents are partial and undefined to the user.

## Timing
- `start` at cycle T: `busy`=1 and `mode`=0 from T+1 (PRIME). First `smp_valid` at T+2.
- With `smp_ready` tied high, LOAD lasts N cycles; sample k is presented at T+2+k.
- Each accepted result is written at the clock edge ending its handshake cycle. Writes are back-to-back with `res_valid` tied high.
- `done` rises the cycle after the N-th result handshake; `busy`=0 one cycle later. A `start` in that IDLE cycle is accepted.
- Minimum transform: 1 + 1 + N + N + 1 cycles from `start` to `done`.
- Address arithmetic: idx and wr_idx are `N_LOG2`+1 bits wide. Termination compares against N-1, so there is no wrap past N-1.

## Test plan
- N_LOG2=3, RAM[i]=i, `smp_ready`=1. `start` -> `smp_data` sequence 0,4,2,6,1,5,3,7 at cycles T+2..T+9; `smp_last` high only with the 7.
- Same setup, `smp_ready` low for 3 cycles while value 2 is presented -> 2 is held stable; no skip or duplicate; the sequence is otherwise unchanged.
- STORE with `res_data`=0xA000_0000+k, `res_valid` toggling 1,0,1,0 -> RAM[k]=0xA000_0000+k for k=0..7. RAM[8..15] unchanged. No write during gap cycles (`write_to_cache`=1 in gaps).
- Full run -> `done` is a single-cycle pulse; `mode`=1 from the `done` cycle; a second `start` 1 cycle after `done` runs correctly.
- `rst` asserted mid-LOAD and mid-STORE -> next cycle: IDLE, `mode`=1, all strobes 0, no further RAM writes.
- `start` held high during a run, and `res_valid`=1 during LOAD -> no restart; no result accepted before STORE.

Source files
------------

// File: rtl/fft_ram_sequencer_if.sv
// ----------------------------------------------------------------------------
// fft_ram_sequencer_if
// Purpose : groups the circuit-side RAM port and the two FFT-core streaming
//           handshakes driven/consumed by fft_ram_sequencer.
// Signals :
//   mode, write_to_cache, read_ram_to_cache, cir_adr_in, cir_data_in  -> RAM
//   cir_data_out                                                      <- RAM
//   smp_data, smp_valid, smp_last / smp_ready   sample stream to the core
//   res_data, res_valid / res_ready             result stream from the core
// Modports: master = sequencer side, slave = RAM / FFT-core side.
// ----------------------------------------------------------------------------
interface fft_ram_sequencer_if #(
    parameter int unsigned ADDR_W = 12
) ();

    // RAM circuit-side port
    logic              mode;
    logic              write_to_cache;
    logic [ADDR_W-1:0] read_ram_to_cache;
    logic [15:0]       cir_data_out;
    logic [ADDR_W-1:0] cir_adr_in;
    logic [31:0]       cir_data_in;

    // Sample stream towards the FFT core
    logic [15:0]       smp_data;
    logic              smp_valid;
    logic              smp_ready;
    logic              smp_last;

    // Result stream from the FFT core
    logic [31:0]       res_data;
    logic              res_valid;
    logic              res_ready;

    modport master (
        output mode,
        output write_to_cache,
        output read_ram_to_cache,
        input  cir_data_out,
        output cir_adr_in,
        output cir_data_in,
        output smp_data,
        output smp_valid,
        input  smp_ready,
        output smp_last,
        input  res_data,
        input  res_valid,
        output res_ready
    );

    modport slave (
        input  mode,
        input  write_to_cache,
        input  read_ram_to_cache,
        output cir_data_out,
        input  cir_adr_in,
        input  cir_data_in,
        input  smp_data,
        input  smp_valid,
        output smp_ready,
        input  smp_last,
        output res_data,
        output res_valid,
        input  res_ready
    );

endinterface

// File: rtl/fft_ram_sequencer.sv
// ----------------------------------------------------------------------------
// fft_ram_sequencer
// Purpose : circuit-side initiator for the shared sample RAM. On i_start it
//           takes the RAM from the AXI side, streams N = 2**N_LOG2 samples to
//           the FFT core in bit-reversed address order, writes the N results
//           back in natural order to addresses 0..N-1, then hands the RAM back
//           and pulses o_done.
// Params  : ADDR_W  RAM address width
//           N_LOG2  log2 of the transform length, legal range 1..ADDR_W
// Ports   : i_clk   clock, all logic on the rising edge
//           i_rst   synchronous active-high reset
//           i_start begin one transform (sampled in IDLE only)
//           o_busy  high in every state except IDLE
//           o_done  one-cycle completion pulse
//           bus     RAM port + sample/result handshakes (master modport)
// ----------------------------------------------------------------------------
module fft_ram_sequencer #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned N_LOG2 = 10
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_start,
    output logic                o_busy,
    output logic                o_done,
    fft_ram_sequencer_if.master bus
);

    // idx/wr_idx carry one spare bit so N itself is representable
    localparam int unsigned     IDX_W    = N_LOG2 + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'((1 << N_LOG2) - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRIME,
        ST_LOAD,
        ST_STORE,
        ST_FINISH
    } state_t;

    state_t            r_state;
    state_t            w_state_next;

    logic [IDX_W-1:0]  r_idx;
    logic [IDX_W-1:0]  w_idx_next;
    logic [IDX_W-1:0]  r_wr_idx;
    logic [IDX_W-1:0]  w_wr_idx_next;

    // Registered, state-decoded outputs
    logic              r_busy;
    logic              r_done;
    logic              r_mode;
    logic              r_smp_valid;
    logic              r_smp_last;
    logic              r_res_ready;
    logic              w_busy_next;
    logic              w_done_next;
    logic              w_mode_next;
    logic              w_smp_valid_next;
    logic              w_smp_last_next;
    logic              w_res_ready_next;

    // Same-cycle RAM controls
    logic              w_write_to_cache;
    logic [ADDR_W-1:0] w_cir_adr;
    logic [31:0]       w_cir_data;
    logic [ADDR_W-1:0] w_rd_adr;

    logic              w_smp_hs;
    logic              w_res_hs;

    assign w_smp_hs = r_smp_valid & bus.smp_ready;
    assign w_res_hs = r_res_ready & bus.res_valid;

    // State and counter registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_idx       <= '0;
            r_wr_idx    <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_mode      <= 1'b1;
            r_smp_valid <= 1'b0;
            r_smp_last  <= 1'b0;
            r_res_ready <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_idx       <= w_idx_next;
            r_wr_idx    <= w_wr_idx_next;
            r_busy      <= w_busy_next;
            r_done      <= w_done_next;
            r_mode      <= w_mode_next;
            r_smp_valid <= w_smp_valid_next;
            r_smp_last  <= w_smp_last_next;
            r_res_ready <= w_res_ready_next;
        end
    end

    // Next-state, counters and RAM strobes
    always_comb begin
        w_state_next     = r_state;
        w_idx_next       = r_idx;
        w_wr_idx_next    = r_wr_idx;
        // Any circuit-owned cycle that is not a committed write must read,
        // otherwise the RAM would write whatever sits on its write port.
        w_write_to_cache = 1'b1;
        w_cir_adr        = '0;
        w_cir_data       = '0;

        unique case (r_state)
            ST_IDLE: begin
                w_write_to_cache = 1'b0;
                if (i_start) begin
                    w_state_next  = ST_PRIME;
                    w_idx_next    = '0;
                    w_wr_idx_next = '0;
                end
            end

            ST_PRIME: begin
                w_state_next = ST_LOAD;
            end

            ST_LOAD: begin
                if (w_smp_hs) begin
                    if (r_idx == LAST_IDX) begin
                        w_state_next = ST_STORE;
                    end else begin
                        w_idx_next = r_idx + IDX_W'(1);
                    end
                end
            end

            ST_STORE: begin
                if (w_res_hs) begin
                    w_write_to_cache = 1'b0;
                    w_cir_adr        = ADDR_W'(r_wr_idx);
                    w_cir_data       = bus.res_data;
                    if (r_wr_idx == LAST_IDX) begin
                        w_state_next = ST_FINISH;
                    end else begin
                        w_wr_idx_next = r_wr_idx + IDX_W'(1);
                    end
                end
            end

            ST_FINISH: begin
                w_write_to_cache = 1'b0;
                w_state_next     = ST_IDLE;
            end

            default: begin
                w_write_to_cache = 1'b0;
                w_state_next     = ST_IDLE;
            end
        endcase

        // Registered outputs follow the state being entered
        w_busy_next      = (w_state_next != ST_IDLE);
        w_done_next      = (w_state_next == ST_FINISH);
        w_mode_next      = (w_state_next == ST_IDLE) || (w_state_next == ST_FINISH);
        w_smp_valid_next = (w_state_next == ST_LOAD);
        w_smp_last_next  = (w_state_next == ST_LOAD) && (w_idx_next == LAST_IDX);
        w_res_ready_next = (w_state_next == ST_STORE);
    end

    // Read address is bitrev(idx_next) so read data lines up with idx next cycle
    for (genvar g = 0; g < ADDR_W; g++) begin : g_rev
        if (g < N_LOG2) begin : g_bit
            assign w_rd_adr[g] = w_idx_next[N_LOG2-1-g];
        end else begin : g_zero
            assign w_rd_adr[g] = 1'b0;
        end
    end

    assign o_busy                = r_busy;
    assign o_done                = r_done;

    assign bus.mode              = r_mode;
    assign bus.write_to_cache    = w_write_to_cache;
    assign bus.read_ram_to_cache = w_rd_adr;
    assign bus.cir_adr_in        = w_cir_adr;
    assign bus.cir_data_in       = w_cir_data;

    assign bus.smp_data          = bus.cir_data_out;
    assign bus.smp_valid         = r_smp_valid;
    assign bus.smp_last          = r_smp_last;
    assign bus.res_ready         = r_res_ready;

endmodule

// File: tb/tb_fft_ram_sequencer.sv
// ----------------------------------------------------------------------------
// tb_fft_ram_sequencer
// Bench for fft_ram_sequencer with N_LOG2=3 against a behavioural 4096x32 RAM.
// Expected samples and expected RAM writes are queued when a transform starts;
// a negedge monitor pops and compares whenever the DUT hands over a sample or
// commits a RAM write.
// ----------------------------------------------------------------------------
module tb_fft_ram_sequencer;

    localparam int unsigned ADDR_W = 12;
    localparam int unsigned N_LOG2 = 3;
    localparam int unsigned N      = 8;
    localparam int unsigned CHK_W  = 16;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic busy;
    logic done;

    fft_ram_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

    fft_ram_sequencer #(
        .ADDR_W (ADDR_W),
        .N_LOG2 (N_LOG2)
    ) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_start (start),
        .o_busy  (busy),
        .o_done  (done),
        .bus     (bus.master)
    );

    always #5 clk = ~clk;

    // Behavioural RAM: circuit write when mode=0 and write_to_cache=0,
    // bench-side (AXI) preload when mode=1; registered 16-bit read.
    logic [31:0]       ram [0:4095];
    logic [31:0]       ref_mem [0:CHK_W-1];
    logic              axi_we;
    logic [ADDR_W-1:0] axi_addr;
    logic [31:0]       axi_data;
    logic [15:0]       rd_q;

    always @(posedge clk) begin
        if (!bus.mode && !bus.write_to_cache) ram[bus.cir_adr_in] <= bus.cir_data_in;
        else if (bus.mode && axi_we)          ram[axi_addr] <= axi_data;
        rd_q <= ram[bus.read_ram_to_cache][15:0];
    end
    assign bus.cir_data_out = rd_q;

    int n_vec = 0;
    int n_err = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Reverse the low N_LOG2 bits of k by arithmetic
    function automatic int unsigned bitrev(input int unsigned k);
        int unsigned r = 0;
        for (int b = 0; b < int'(N_LOG2); b++) r = r * 2 + ((k >> b) & 1);
        return r;
    endfunction

    typedef struct packed {
        logic [15:0] data;
        logic        last;
    } smp_t;

    typedef struct packed {
        logic [ADDR_W-1:0] adr;
        logic [31:0]       data;
    } wr_t;

    smp_t q_smp[$];
    wr_t  q_wr[$];
    smp_t mon_s;
    wr_t  mon_w;
    logic        prev_stall;
    logic [15:0] prev_data;

    // Monitor: sample handshakes, sample hold, RAM writes
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (bus.smp_valid && prev_stall)
                chk("smp_hold", 32'(bus.smp_data), 32'(prev_data));
            if (bus.smp_valid && bus.smp_ready) begin
                if (q_smp.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL smp_extra: got sample 0x%04h, expected none", bus.smp_data);
                end else begin
                    mon_s = q_smp.pop_front();
                    chk("smp_data", 32'(bus.smp_data), 32'(mon_s.data));
                    chk("smp_last", 32'(bus.smp_last), 32'(mon_s.last));
                end
            end
            if (!bus.mode && !bus.write_to_cache) begin
                if (q_wr.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL wr_extra: got write 0x%08h @0x%03h, expected none",
                             bus.cir_data_in, bus.cir_adr_in);
                end else begin
                    mon_w = q_wr.pop_front();
                    chk("wr_addr", 32'(bus.cir_adr_in), 32'(mon_w.adr));
                    chk("wr_data", bus.cir_data_in, mon_w.data);
                end
            end
            prev_stall = bus.smp_valid && !bus.smp_ready;
            prev_data  = bus.smp_data;
        end
    end

    task automatic check_idle(input string tag);
        chk({tag, "_busy"},  32'(busy), 32'd0);
        chk({tag, "_done"},  32'(done), 32'd0);
        chk({tag, "_mode"},  32'(bus.mode), 32'd1);
        chk({tag, "_wtc"},   32'(bus.write_to_cache), 32'd0);
        chk({tag, "_sval"},  32'(bus.smp_valid), 32'd0);
        chk({tag, "_slast"}, 32'(bus.smp_last), 32'd0);
        chk({tag, "_rrdy"},  32'(bus.res_ready), 32'd0);
        chk({tag, "_radr"},  32'(bus.read_ram_to_cache), 32'd0);
        chk({tag, "_wadr"},  32'(bus.cir_adr_in), 32'd0);
        chk({tag, "_wdat"},  bus.cir_data_in, 32'd0);
    endtask

    // Load RAM[0..CHK_W-1] through the AXI-side port while the DUT is idle
    task automatic preload(input bit directed);
        for (int a = 0; a < int'(CHK_W); a++) begin
            @(posedge clk); #1;
            axi_we   = 1'b1;
            axi_addr = ADDR_W'(a);
            axi_data = directed ? 32'(a) : $urandom;
            ref_mem[4'(a)] = axi_data;
        end
        @(posedge clk); #1;
        axi_we = 1'b0;
    endtask

    // One transform.
    // rmode: 0 ready high, 1 three-cycle stall on sample 2, 2 random
    // vmode: 0 valid high, 1 toggling 1,0,1,0, 2 random
    // rst_phase: 0 none, 1 reset mid-LOAD, 2 reset mid-STORE
    task automatic run(input int rmode, input int vmode, input bit directed,
                       input bit hold_start, input bit early, input bit pre_started,
                       input bit chain_next, input int rst_phase);
        logic [31:0] res_vals [N];
        int  scnt, ri, stall_left;
        bit  seen_done, first, tog, v;

        for (int k = 0; k < int'(N); k++)
            q_smp.push_back('{data: ref_mem[4'(bitrev(k))][15:0], last: (k == int'(N) - 1)});
        for (int k = 0; k < int'(N); k++) begin
            res_vals[k] = directed ? 32'hA000_0000 + 32'(k) : $urandom;
            q_wr.push_back('{adr: ADDR_W'(k), data: res_vals[k]});
            ref_mem[4'(k)] = res_vals[k];
        end

        if (!pre_started) begin
            @(posedge clk); #1;
            start = 1'b1;
            @(negedge clk);
        end

        // PRIME cycle
        @(posedge clk); #1;
        if (!hold_start) start = 1'b0;
        bus.smp_ready = 1'b1;
        bus.res_valid = early;
        bus.res_data  = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("prime_busy",  32'(busy), 32'd1);
        chk("prime_mode",  32'(bus.mode), 32'd0);
        chk("prime_sval",  32'(bus.smp_valid), 32'd0);

        scnt = 0; ri = 0; stall_left = 3;
        seen_done = 1'b0; first = 1'b1; tog = 1'b1;
        for (int cyc = 0; cyc < 400 && !seen_done; cyc++) begin
            @(posedge clk); #1;
            if ((rst_phase == 1 && scnt == 3) || (rst_phase == 2 && ri == 3)) begin
                rst = 1'b1; start = 1'b0;
                bus.smp_ready = 1'b0; bus.res_valid = 1'b0;
                @(posedge clk); #1;
                rst = 1'b0;
                q_smp.delete();
                q_wr.delete();
                @(negedge clk);
                check_idle(rst_phase == 1 ? "rst_load" : "rst_store");
                repeat (4) @(negedge clk);
                return;
            end
            case (rmode)
                0: bus.smp_ready = 1'b1;
                1: begin
                    if (scnt == 2 && stall_left > 0) begin
                        bus.smp_ready = 1'b0;
                        stall_left--;
                    end else begin
                        bus.smp_ready = 1'b1;
                    end
                end
                default: bus.smp_ready = ($urandom_range(0, 3) != 0);
            endcase
            if (scnt < int'(N)) begin
                bus.res_valid = early;
                bus.res_data  = 32'hDEAD_0000 | 32'(cyc);
            end else if (ri < int'(N)) begin
                case (vmode)
                    0:       v = 1'b1;
                    1:       begin v = tog; tog = !tog; end
                    default: v = 1'($urandom_range(0, 1));
                endcase
                bus.res_valid = v;
                bus.res_data  = v ? res_vals[ri] : (32'hBAD0_0000 | 32'(ri));
            end else begin
                bus.res_valid = 1'b0;
            end
            @(negedge clk);
            if (first) begin
                chk("load_first_sval", 32'(bus.smp_valid), 32'd1);
                first = 1'b0;
            end
            if (bus.smp_valid && bus.smp_ready) scnt++;
            if (bus.res_valid && bus.res_ready) ri++;
            if (done) begin
                seen_done = 1'b1;
                chk("done_mode", 32'(bus.mode), 32'd1);
                chk("done_busy", 32'(busy), 32'd1);
                chk("smp_count", 32'(scnt), 32'(N));
                chk("res_count", 32'(ri), 32'(N));
            end
        end

        if (!seen_done) begin
            n_vec++; n_err++;
            $display("FAIL done_timeout: got no done, expected done within 400 cycles");
        end

        // IDLE cycle after FINISH
        @(posedge clk); #1;
        start         = chain_next;
        bus.smp_ready = 1'b0;
        bus.res_valid = 1'b0;
        @(negedge clk);
        chk("post_done", 32'(done), 32'd0);
        chk("post_busy", 32'(busy), 32'd0);
        chk("post_mode", 32'(bus.mode), 32'd1);
        chk("q_smp_left", 32'(q_smp.size()), 32'd0);
        chk("q_wr_left",  32'(q_wr.size()), 32'd0);
        for (int a = 0; a < int'(CHK_W); a++)
            chk("ram_word", ram[a], ref_mem[4'(a)]);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0;
        axi_we = 1'b0; axi_addr = '0; axi_data = '0;
        bus.smp_ready = 1'b0; bus.res_valid = 1'b0; bus.res_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        // RAM[i]=i, ready high, results toggling
        preload(1'b1);
        run(0, 1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        // sample 2 stalled three cycles, then back-to-back start
        preload(1'b1);
        run(1, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        run(0, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0);
        // start held high, res_valid asserted through LOAD
        run(2, 2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0);
        // resets mid-LOAD and mid-STORE
        preload(1'b0);
        run(2, 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1);
        preload(1'b0);
        run(0, 2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2);
        // random contents and handshakes
        for (int t = 0; t < 6; t++) begin
            preload(1'b0);
            run(2, 2, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 1'b0, 0);
        end

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
